// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA timing generator with two-stage frame buffer scanout
module vga_scanout #(
  parameter int VERT_RESOLUTION  = 60,
  parameter int HORIZ_RESOLUTION = 80,
  parameter int COLOR_DEPTH      = 12,
  parameter int Z_DEPTH          = 2,
  parameter int SCALE_LOG2       = 3,
  parameter int H_FRONT          = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BACK           = 48,
  parameter int V_FRONT          = 10,
  parameter int V_SYNC           = 2,
  parameter int V_BACK           = 33
) (
  input  logic                                i_vga_clk,
  input  logic                                i_rst_n,
  output logic [$clog2(VERT_RESOLUTION)-1:0]  o_vga_vert_read_addr,
  output logic [$clog2(HORIZ_RESOLUTION)-1:0] o_vga_horiz_read_addr,
  input  logic [COLOR_DEPTH+Z_DEPTH-1:0]      i_vga_read_pixel_data,
  output logic [COLOR_DEPTH/3-1:0]            o_red,
  output logic [COLOR_DEPTH/3-1:0]            o_green,
  output logic [COLOR_DEPTH/3-1:0]            o_blue,
  output logic                                o_hsync,
  output logic                                o_vsync,
  output logic                                o_vblank,
  output logic                                o_frame_done
);

  // Screen geometry in pixel clocks and lines
  localparam int H_ACTIVE = HORIZ_RESOLUTION << SCALE_LOG2;
  localparam int V_ACTIVE = VERT_RESOLUTION << SCALE_LOG2;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam int HC_W = $clog2(H_TOTAL);
  localparam int VC_W = $clog2(V_TOTAL);
  localparam int VA_W = $clog2(VERT_RESOLUTION);
  localparam int HA_W = $clog2(HORIZ_RESOLUTION);
  localparam int CW   = COLOR_DEPTH / 3;

  // Counter-width constants so every compare is width-matched
  localparam logic [HC_W-1:0] H_LAST       = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] H_ACT        = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] H_SYNC_START = HC_W'(H_ACTIVE + H_FRONT);
  localparam logic [HC_W-1:0] H_SYNC_END   = HC_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VC_W-1:0] V_LAST       = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] V_ACT        = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] V_SYNC_START = VC_W'(V_ACTIVE + V_FRONT);
  localparam logic [VC_W-1:0] V_SYNC_END   = VC_W'(V_ACTIVE + V_FRONT + V_SYNC);

  // Stage 0: raster position
  logic [HC_W-1:0] h_cnt;
  logic [VC_W-1:0] v_cnt;

  // Stage 0 decoded flags
  logic active;
  logic hsync_raw;
  logic vsync_raw;
  logic vblank_raw;
  logic frame_done_raw;

  // Stage 1 flags, aligned with the pixel returned by the frame buffer
  logic s1_active;
  logic s1_hsync;
  logic s1_vsync;
  logic s1_vblank;
  logic s1_frame_done;

  // Colour field of the returned pixel; depth bits are not displayed
  logic [COLOR_DEPTH-1:0] pix_color;
  logic                   z_unused;

  assign pix_color = i_vga_read_pixel_data[COLOR_DEPTH+Z_DEPTH-1:Z_DEPTH];
  assign z_unused  = ^i_vga_read_pixel_data[Z_DEPTH-1:0];

  // Raster scan: h_cnt every clock, v_cnt on each line wrap
  always_ff @(posedge i_vga_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + 1'b1;
      end
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Decode region/sync flags and the frame buffer read address from the counters
  always_comb begin
    active         = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hsync_raw      = !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
    vsync_raw      = !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
    vblank_raw     = (v_cnt >= V_ACT);
    frame_done_raw = (v_cnt == V_ACT) && (h_cnt == '0);

    o_vga_vert_read_addr  = '0;
    o_vga_horiz_read_addr = '0;
    if (active) begin
      o_vga_vert_read_addr  = VA_W'(v_cnt >> SCALE_LOG2);
      o_vga_horiz_read_addr = HA_W'(h_cnt >> SCALE_LOG2);
    end
  end

  // Stage 1: hold the flags while the frame buffer read is in flight
  always_ff @(posedge i_vga_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_active     <= 1'b0;
      s1_hsync      <= 1'b1;
      s1_vsync      <= 1'b1;
      s1_vblank     <= 1'b0;
      s1_frame_done <= 1'b0;
    end else begin
      s1_active     <= active;
      s1_hsync      <= hsync_raw;
      s1_vsync      <= vsync_raw;
      s1_vblank     <= vblank_raw;
      s1_frame_done <= frame_done_raw;
    end
  end

  // Stage 2: register colour and sync together so they leave with no skew
  always_ff @(posedge i_vga_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_red        <= '0;
      o_green      <= '0;
      o_blue       <= '0;
      o_hsync      <= 1'b1;
      o_vsync      <= 1'b1;
      o_vblank     <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_hsync      <= s1_hsync;
      o_vsync      <= s1_vsync;
      o_vblank     <= s1_vblank;
      o_frame_done <= s1_frame_done;
      if (s1_active) begin
        o_red   <= pix_color[COLOR_DEPTH-1 -: CW];
        o_green <= pix_color[COLOR_DEPTH-1-CW -: CW];
        o_blue  <= pix_color[COLOR_DEPTH-1-2*CW -: CW];
      end else begin
        o_red   <= '0;
        o_green <= '0;
        o_blue  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - randomized model-checked bench for vga_scanout
`timescale 1ns/1ps
module tb_vga_scanout;

  // Line timing shared by every instance (640 active + 16 + 96 + 48)
  localparam int HT  = 800;
  localparam int HA  = 640;
  localparam int HS0 = HA + 16;
  localparam int HS1 = HA + 16 + 96;
  // Main instance: 2 buffer rows -> 16 active lines, 61 lines per frame
  localparam int M_VA    = 2 << 3;
  localparam int M_VT    = M_VA + 10 + 2 + 33;
  localparam int M_VS0   = M_VA + 10;
  localparam int M_VS1   = M_VA + 12;
  localparam int M_FRAME = HT * M_VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance (reduced vertical resolution, full model check every clock)
  logic [0:0]  m_va;
  logic [6:0]  m_ha;
  logic [13:0] m_pix;
  logic [3:0]  m_r, m_g, m_b;
  logic        m_hs, m_vs, m_vb, m_fd;
  // Default-parameter instance (spot checks)
  logic [5:0]  d_va;
  logic [6:0]  d_ha;
  logic [13:0] d_pix;
  logic [3:0]  d_r, d_g, d_b;
  logic        d_hs, d_vs, d_vb, d_fd;
  // SCALE_LOG2=2 instance
  logic [1:0]  s_va;
  logic [7:0]  s_ha;
  logic [13:0] s_pix;
  logic [3:0]  s_r, s_g, s_b;
  logic        s_hs, s_vs, s_vb, s_fd;

  vga_scanout #(.VERT_RESOLUTION(2)) u_dut (
    .i_vga_clk(clk), .i_rst_n(rst_n),
    .o_vga_vert_read_addr(m_va), .o_vga_horiz_read_addr(m_ha),
    .i_vga_read_pixel_data(m_pix),
    .o_red(m_r), .o_green(m_g), .o_blue(m_b),
    .o_hsync(m_hs), .o_vsync(m_vs), .o_vblank(m_vb), .o_frame_done(m_fd)
  );

  vga_scanout u_dflt (
    .i_vga_clk(clk), .i_rst_n(rst_n),
    .o_vga_vert_read_addr(d_va), .o_vga_horiz_read_addr(d_ha),
    .i_vga_read_pixel_data(d_pix),
    .o_red(d_r), .o_green(d_g), .o_blue(d_b),
    .o_hsync(d_hs), .o_vsync(d_vs), .o_vblank(d_vb), .o_frame_done(d_fd)
  );

  vga_scanout #(.SCALE_LOG2(2), .HORIZ_RESOLUTION(160), .VERT_RESOLUTION(4)) u_s2 (
    .i_vga_clk(clk), .i_rst_n(rst_n),
    .o_vga_vert_read_addr(s_va), .o_vga_horiz_read_addr(s_ha),
    .i_vga_read_pixel_data(s_pix),
    .o_red(s_r), .o_green(s_g), .o_blue(s_b),
    .o_hsync(s_hs), .o_vsync(s_vs), .o_vblank(s_vb), .o_frame_done(s_fd)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Frame buffer contents for the main instance
  logic [11:0] fb [0:1][0:79];

  function automatic logic [11:0] colour_d(input logic [5:0] row, input logic [6:0] col);
    logic [13:0] pixel;
    pixel = {row, col, 1'b0};
    return pixel[11:0];
  endfunction

  // Registered-read RAM models: data valid one clock after the address
  always @(posedge clk) begin
    m_pix <= {fb[m_va][m_ha], 2'($urandom)};
    d_pix <= {colour_d(d_va, d_ha), 2'b11};
    s_pix <= 14'($urandom);
  end

  // Clock edges since the last reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic mon_en = 1'b0;
  logic main_run = 1'b0;
  logic stat_on = 1'b0;
  logic stat_done = 1'b0;
  int   fd_t, hs_low, vs_low;
  int   k, x, y, px, py;
  logic act, e_hs, e_vs, e_vb, e_fd;
  logic [11:0] e_col;

  // Reference model: outputs reflect the raster position two clocks earlier
  always @(negedge clk) begin
    if (mon_en) begin
      k = cyc;
      x = k % HT;
      y = (k / HT) % M_VT;
      act = (x < HA) && (y < M_VA);
      check("m_vaddr", m_va, act ? (y >> 3) : 0);
      check("m_haddr", m_ha, act ? (x >> 3) : 0);
      if (k < 2) begin
        e_hs = 1'b1; e_vs = 1'b1; e_vb = 1'b0; e_fd = 1'b0; e_col = '0;
      end else begin
        px = (k - 2) % HT;
        py = ((k - 2) / HT) % M_VT;
        e_hs  = !(px >= HS0 && px < HS1);
        e_vs  = !(py >= M_VS0 && py < M_VS1);
        e_vb  = (py >= M_VA);
        e_fd  = (py == M_VA) && (px == 0);
        e_col = (px < HA && py < M_VA) ? fb[py >> 3][px >> 3] : 12'h000;
      end
      check("m_hsync", m_hs, e_hs);
      check("m_vsync", m_vs, e_vs);
      check("m_vblank", m_vb, e_vb);
      check("m_frame_done", m_fd, e_fd);
      check("m_rgb", {m_r, m_g, m_b}, e_col);

      if (main_run && !stat_done) begin
        if (m_fd && stat_on) begin
          check("fd_period", k - fd_t, M_FRAME);
          check("hs_low_per_frame", hs_low, M_VT * 96);
          check("vs_low_per_frame", vs_low, 2 * HT);
          stat_done = 1'b1;
        end else begin
          if (m_fd) begin
            stat_on = 1'b1;
            fd_t = k;
          end
          if (stat_on) begin
            if (!m_hs) hs_low++;
            if (!m_vs) vs_low++;
          end
        end
      end

      if (main_run) begin
        if (k == 5) begin
          check("d_vsync_idle", d_vs, 1);
          check("d_vblank_idle", d_vb, 0);
          check("d_fd_idle", d_fd, 0);
        end
        if (k == 7217) begin
          check("d_vaddr_17_9", d_va, 1);
          check("d_haddr_17_9", d_ha, 2);
        end
        if (k == 7219) check("d_rgb_17_9", {d_r, d_g, d_b}, 12'h104);
        if (k == 639) begin
          check("d_haddr_639", d_ha, 79);
          check("d_vaddr_639", d_va, 0);
        end
        if (k == 640) begin
          check("d_haddr_640", d_ha, 0);
          check("d_vaddr_640", d_va, 0);
        end
        if (k == 641) check("d_rgb_639", {d_r, d_g, d_b}, colour_d(6'd0, 7'd79));
        if (k == 642) check("d_rgb_640", {d_r, d_g, d_b}, 0);
        if (k == 657) check("d_hsync_657", d_hs, 1);
        if (k == 658) check("d_hsync_658", d_hs, 0);
        if (k >= 1 && k < 64) begin
          check("s_haddr", s_ha, k >> 2);
          check("s_vaddr", s_va, 0);
        end
        if (k == 658) check("s_hsync_658", s_hs, 0);
        if (k == 12801) check("s_vblank_pre", s_vb, 0);
        if (k == 12802) begin
          check("s_vblank_rise", s_vb, 1);
          check("s_frame_done", s_fd, 1);
          check("s_vsync", s_vs, 1);
          check("s_rgb_blank", {s_r, s_g, s_b}, 0);
        end
        if (k == 15 * HT + 102) check("m_rgb_y15", {m_r, m_g, m_b}, fb[1][12]);
        if (k == 16 * HT + 102) check("m_rgb_y16", {m_r, m_g, m_b}, 0);
        if (k == M_FRAME + 1) check("m_vblank_wrap_pre", m_vb, 1);
        if (k == M_FRAME + 2) begin
          check("m_vblank_wrap", m_vb, 0);
          check("m_rgb_wrap", {m_r, m_g, m_b}, fb[0][0]);
        end
      end
    end
  end

  task automatic check_reset_now(input string tag);
    check({tag, "_hsync"}, m_hs, 1);
    check({tag, "_vsync"}, m_vs, 1);
    check({tag, "_vblank"}, m_vb, 0);
    check({tag, "_fd"}, m_fd, 0);
    check({tag, "_rgb"}, {m_r, m_g, m_b}, 0);
    check({tag, "_addr"}, {m_va, m_ha}, 0);
  endtask

  int target;
  int guard;

  initial begin
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 80; c++)
        fb[r][c] = 12'($urandom_range(1, 4095));
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Random-length run, then an asynchronous reset between edges
    repeat ($urandom_range(100, 700)) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_now("rst_early");
    repeat ($urandom_range(1, 4)) @(negedge clk);
    #2 rst_n = 1'b1;
    main_run = 1'b1;

    // Run into the vsync pulse of the second frame
    target = M_FRAME + M_VS0 * HT + HT + $urandom_range(10, 600);
    guard = 0;
    while (cyc != target && guard < 90000) begin
      @(negedge clk);
      guard++;
    end
    check("reach_target", cyc, target);
    check("vsync_before_rst", m_vs, 0);
    #2 rst_n = 1'b0;
    #1 check_reset_now("rst_in_vsync");
    repeat ($urandom_range(1, 5)) @(negedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (m_hs == 1'b0) break;
    end
    check("hsync_fall_after_rst", cyc, 2 + HS0);
    check("d_hsync_fall_after_rst", d_hs, 0);
    repeat (20) @(negedge clk);
    check("frame_stats_seen", stat_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
